// File: rtl/fxp_pkg.sv
// fxp_pkg: fixed-point saturation helpers shared by the shrink scheduler
package fxp_pkg;
  localparam int Y_INT_REQ = 1;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
  function automatic bit shrink_ok(input int xw, input int xi, input int yw, input int yi);
    return (xw - xi >= yw - 1) && (yi == Y_INT_REQ);
  endfunction
endpackage

// File: rtl/shrink_rr_scheduler_if.sv
// shrink_rr_scheduler_if: per-channel sample inputs and the shared narrow output bus
interface shrink_rr_scheduler_if
  import fxp_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int X_DATA_WIDTH = 47,
  parameter int Y_DATA_WIDTH = 31
);
  localparam int CW = ch_w(N_CH);
  logic [N_CH-1:0]              in_valid;
  logic [N_CH-1:0]              in_ready;
  logic [N_CH*X_DATA_WIDTH-1:0] in_x;
  logic                         out_valid;
  logic                         out_ready;
  logic [Y_DATA_WIDTH-1:0]      out_y;
  logic [CW-1:0]                out_ch;
  logic                         out_sat;
  modport slave (input in_valid, in_x, out_ready, output in_ready, out_valid, out_y, out_ch, out_sat);
  modport master (output in_valid, in_x, out_ready, input in_ready, out_valid, out_y, out_ch, out_sat);
endinterface

// File: rtl/fxp_sat_shrink.sv
// fxp_sat_shrink: combinational wide-to-narrow Q conversion with clamp and truncation
module fxp_sat_shrink
  import fxp_pkg::*;
#(
  parameter int XW = 47,
  parameter int XI = 5,
  parameter int YW = 31
) (
  input  logic [XW-1:0] x_i,
  output logic [YW-1:0] y_o,
  output logic          sat_o
);
  localparam int F = XW - XI;
  localparam logic [YW-1:0] Y_MAX = YW'(sat_max(YW));
  localparam logic [YW-1:0] Y_MIN = YW'(sat_min(YW));
  logic sign, pos_ovf, neg_ovf;
  // the sign bit is folded into the integer-field test; it matches the sign by definition
  assign sign    = x_i[XW-1];
  assign pos_ovf = !sign && (|x_i[XW-1:F]);
  assign neg_ovf = sign && !(&x_i[XW-1:F]);
  assign sat_o   = pos_ovf || neg_ovf;
  assign y_o     = pos_ovf ? Y_MAX : neg_ovf ? Y_MIN : {sign, x_i[F-1 -: YW-1]};
  if (F >= YW) begin : g_trunc
    logic unused_lsb;
    assign unused_lsb = ^x_i[F-YW:0];
  end
endmodule

// File: rtl/shrink_rr_scheduler.sv
// shrink_rr_scheduler: round-robin share of one saturating shrink stage across N_CH channels
module shrink_rr_scheduler
  import fxp_pkg::*;
#(
  parameter int N_CH             = 4,
  parameter int X_DATA_WIDTH     = 47,
  parameter int X_DATA_WIDTH_INT = 5,
  parameter int Y_DATA_WIDTH     = 31,
  parameter int Y_DATA_WIDTH_INT = 1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  shrink_rr_scheduler_if.slave      bus,
  input  logic                      clr_stats,
  output logic [N_CH*CNT_WIDTH-1:0] sat_cnt,
  output logic [N_CH-1:0]           sat_sticky
);
  localparam int CW = ch_w(N_CH);
  if (!shrink_ok(X_DATA_WIDTH, X_DATA_WIDTH_INT, Y_DATA_WIDTH, Y_DATA_WIDTH_INT)) begin : g_bad_cfg
    $error("shrink_rr_scheduler: unsupported X/Y fixed-point format");
  end
  logic                    out_valid_q, out_sat_q, can_acc, found, gnt, sat;
  logic [Y_DATA_WIDTH-1:0] out_y_q, y;
  logic [CW-1:0]           out_ch_q, last_q, g;
  logic [X_DATA_WIDTH-1:0] x_g;
  logic [CNT_WIDTH-1:0]    cnt_q [N_CH];
  logic [N_CH-1:0]         sticky_q;
  assign can_acc = !out_valid_q || bus.out_ready;
  // search starts just after the last winner so every waiting channel gets a turn within N_CH grants
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!found && bus.in_valid[(int'(last_q) + k) % N_CH]) begin
        found = 1'b1;
        g = CW'((int'(last_q) + k) % N_CH);
      end
    end
  end
  assign gnt = found && can_acc && !rst;
  always_comb begin
    for (int i = 0; i < N_CH; i++) bus.in_ready[i] = gnt && (g == CW'(i));
  end
  assign x_g = bus.in_x[g*X_DATA_WIDTH +: X_DATA_WIDTH];
  fxp_sat_shrink #(
    .XW(X_DATA_WIDTH),
    .XI(X_DATA_WIDTH_INT),
    .YW(Y_DATA_WIDTH)
  ) u_shrink (
    .x_i  (x_g),
    .y_o  (y),
    .sat_o(sat)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
      last_q      <= CW'(N_CH - 1);
    end else if (gnt) begin
      out_valid_q <= 1'b1;
      out_y_q     <= y;
      out_ch_q    <= g;
      out_sat_q   <= sat;
      last_q      <= g;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr_stats) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      sticky_q <= '0;
    end else if (gnt && sat) begin
      if (cnt_q[g] != '1) cnt_q[g] <= cnt_q[g] + 1'b1;
      sticky_q[g] <= 1'b1;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_sticky    = sticky_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_cnt
    assign sat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end
endmodule

// File: doc/shrink_rr_scheduler.md
# shrink_rr_scheduler

Round-robin scheduler that shares one saturating fixed-point shrink stage (wide Q-format to narrow Q-format) between N_CH requesting channels. Each channel offers wide samples over a valid/ready handshake. The block grants one channel per cycle, converts the sample with saturation, and registers the result with its channel tag onto a single valid/ready output. It also keeps per-channel saturation statistics for software. It sits between the per-channel accumulators and the narrow downstream bus.

## Interface
- N_CH, 4: number of requesting channels, 2..16.
- X_DATA_WIDTH, 47: input word width, two's complement.
- X_DATA_WIDTH_INT, 5: input integer bits, sign bit included.
- Y_DATA_WIDTH, 31: output word width.
- Y_DATA_WIDTH_INT, 1: output integer bits, sign bit included. Must be 1.
- CNT_WIDTH, 16: width of each saturation counter.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N_CH  per-channel sample valid.
- in_ready  out  N_CH  per-channel accept; one-hot or zero.
- in_x  in  N_CH*X_DATA_WIDTH  channel i at slice [i*X_DATA_WIDTH +: X_DATA_WIDTH].
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts.
- out_y  out  Y_DATA_WIDTH  converted sample.
- out_ch  out  $clog2(N_CH)  source channel of out_y.
- out_sat  out  1  out_y was clamped.
- clr_stats  in  1  synchronous clear of counters and sticky flags.
- sat_cnt  out  N_CH*CNT_WIDTH  per-channel saturation event counts.
- sat_sticky  out  N_CH  per-channel "saturated since clear" flags.

## Operation
- Elaboration constraint: X_DATA_WIDTH-X_DATA_WIDTH_INT >= Y_DATA_WIDTH-1. Violation causes an elaboration error.
- Stage free (`can_acc`) when `!out_valid || out_ready`.
- Arbitration: rotating pointer `last` holds the most recently granted channel. Search order is last+1, last+2, … wrapping modulo N_CH. The first channel with in_valid is granted when can_acc. in_ready[g] = 1 for that channel only. On grant, `last <= g`.
- in_ready is a combinational function of in_valid, out_valid, out_ready and `last`. It never depends on in_x.
- Conversion of granted x (F = X_DATA_WIDTH-X_DATA_WIDTH_INT):
  - Integer field is x[X_DATA_WIDTH-2:F].
  - If the sign is 0 and the integer field is not all 0: y = 0 followed by all ones (max positive), sat = 1.
  - If the sign is 1 and the integer field is not all 1: y = 1 followed by all zeros (most negative), sat = 1.
  - Otherwise y = {sign, x[F-1 : F-(Y_DATA_WIDTH-1)]}, sat = 0. Remaining low bits are truncated; no rounding.
- On grant, the block loads out_y, out_ch = g, out_sat and sets out_valid. Without a grant, out_valid clears once out_ready is seen.
- Statistics: on a grant with sat = 1, sat_cnt[g] increments, saturating at all ones (no wrap), and sat_sticky[g] is set.
- clr_stats in a cycle zeroes all counters and sticky flags. Clear wins over a same-cycle increment.

## Timing
- Latency is 1 cycle: input handshake at edge k gives out_valid with data valid after edge k.
- Full throughput of one sample per cycle when out_ready stays high.
- Backpressure: while out_valid && !out_ready, all in_ready are 0 and out_* stay stable.
- Simultaneous out_ready and a new grant in the same cycle: the old result leaves and the new one loads. No bubble.
- Reset values:
  - out_valid = 0, out_y = 0, out_ch = 0, out_sat = 0.
  - All sat_cnt = 0, all sat_sticky = 0.
  - `last` = N_CH-1, so channel 0 has first priority.
  - in_ready = 0 while rst is high.
- Reset mid-transfer drops any held result; the requester must re-offer it.
- Fairness: a continuously valid channel is granted within N_CH grants.

## Structure
- Shared package `fxp_pkg`:
  - saturation constant functions (max/min patterns for a given width);
  - a `clog2`-based channel-index width helper;
  - a constant for the elaboration-constraint check.
- One sub-module: `fxp_sat_shrink`, a purely combinational conversion taking x and producing {y, sat}. It is instantiated once after the grant mux.
- Arbiter, output register and counters live in the top module.

## Test plan
1. Defaults, channel 1 only, x=47'h0200_0000_0000 (+0.5) -> one cycle later out_valid=1, out_y=31'h2000_0000, out_ch=1, out_sat=0.
2. Channel 0 x=47'h0400_0000_0000 (+1.0), channel 2 x=47'h7800_0000_0000 (-2.0) -> out_y=31'h3FFF_FFFF then 31'h4000_0000, both out_sat=1. sat_cnt[0]=1, sat_cnt[2]=1, sticky bits 0 and 2 set.
3. x=47'h7C00_0000_0000 (-1.0) -> out_y=31'h4000_0000, out_sat=0, counters unchanged.
4. All 4 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,… with one result per cycle. Then hold out_ready=0 for 5 cycles -> in_ready=0 and out_* stable. Release -> sequence resumes with no loss or duplication.
5. Force sat_cnt[3] to 16'hFFFE via 2 further saturating samples after preload -> count stops at 16'hFFFF. Assert clr_stats together with a saturating grant -> count=0, sticky=0.
6. Assert rst asynchronously while out_valid=1 and out_ready=0 -> out_valid drops immediately. After release, channel 0 wins first when all channels are valid.
